// File: rtl/sseg_scan_ctrl.sv
// Memory-mapped four-digit seven-segment scanner for the OTTER IOBUS.
// Hex-decodes a 16-bit value and multiplexes active-low anodes with ghost blanking.
module sseg_scan_ctrl #(
   parameter int          CLKS_PER_DIGIT = 25000,
   parameter int          GHOST_CLKS     = 16,
   parameter logic [31:0] VALUE_ADDR     = 32'h1100C00C,
   parameter logic [31:0] CTRL_ADDR      = 32'h1100C010
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [7:0]  SEGS,
   output logic [3:0]  AN
);

   localparam int                CNT_W     = $clog2(CLKS_PER_DIGIT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_DIGIT - 1);
   localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CLKS);

   logic [15:0]      r_value;
   logic [9:0]       r_ctrl;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_idx;
   logic [3:0]       r_an;
   logic [7:0]       r_segs;

   logic [15:0] w_shift;
   logic [3:0]  w_nib;
   logic [3:0]  w_en_sh;
   logic [3:0]  w_dp_sh;
   logic        w_lzb;
   logic        w_blank;
   logic [3:0]  w_an;
   logic [7:0]  w_segs;
   logic        w_unused_bus;

   // Upper data bits are never stored.
   assign w_unused_bus = ^IOBUS_OUT[31:16];

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      case (nib)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   // Shifting the value down by the digit index gives both the nibble and
   // the "everything at or above this digit is zero" test for LZB.
   always_comb begin
      w_shift = r_value >> {r_idx, 2'b00};
      w_nib   = w_shift[3:0];
      w_en_sh = r_ctrl[3:0] >> r_idx;
      w_dp_sh = r_ctrl[7:4] >> r_idx;
      w_lzb   = r_ctrl[8] && (r_idx != 2'd0) && (w_shift == 16'h0000);
      w_blank = !r_ctrl[9] || !w_en_sh[0] || (r_cnt < CNT_GHOST) || w_lzb;
      w_an    = ~(4'b0001 << r_idx);
      w_segs  = {~w_dp_sh[0], hex7(w_nib)};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_value <= 16'h0000;
         r_ctrl  <= 10'h20F;
         r_cnt   <= '0;
         r_idx   <= 2'd0;
         r_an    <= 4'hF;
         r_segs  <= 8'hFF;
      end else begin
         if (IOBUS_WR) begin
            if (IOBUS_ADDR == VALUE_ADDR)
               r_value <= IOBUS_OUT[15:0];
            else if (IOBUS_ADDR == CTRL_ADDR)
               r_ctrl <= IOBUS_OUT[9:0];
         end

         if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         r_an   <= w_blank ? 4'hF  : w_an;
         r_segs <= w_blank ? 8'hFF : w_segs;
      end
   end

   assign AN   = r_an;
   assign SEGS = r_segs;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with an 8-cycle slot and 2-cycle ghost window.
module tb_sseg_scan_ctrl;

   localparam logic [31:0] VALUE_ADDR = 32'h1100C00C;
   localparam logic [31:0] CTRL_ADDR  = 32'h1100C010;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] IOBUS_ADDR = '0;
   logic [31:0] IOBUS_OUT  = '0;
   logic        IOBUS_WR   = 1'b0;
   logic [7:0]  SEGS;
   logic [3:0]  AN;

   int n_cmp  = 0;
   int n_fail = 0;
   int ecount = 0;

   typedef struct {
      logic             skip_wr;
      logic [9:0]       ctrl;
      logic [15:0]      value;
      logic [3:0][3:0]  an;    // {slot3, slot2, slot1, slot0}
      logic [3:0][7:0]  segs;
   } vec_t;

   vec_t vecs[10];

   sseg_scan_ctrl #(
      .CLKS_PER_DIGIT(8),
      .GHOST_CLKS    (2),
      .VALUE_ADDR    (VALUE_ADDR),
      .CTRL_ADDR     (CTRL_ADDR)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IOBUS_ADDR(IOBUS_ADDR),
      .IOBUS_OUT (IOBUS_OUT),
      .IOBUS_WR  (IOBUS_WR),
      .SEGS      (SEGS),
      .AN        (AN)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
      ecount++;
   endtask

   task automatic check(input string name, input logic [3:0] exp_an, input logic [7:0] exp_segs);
      n_cmp++;
      if (AN !== exp_an || SEGS !== exp_segs) begin
         n_fail++;
         $display("FAIL %s: got AN=%h SEGS=%h, want AN=%h SEGS=%h", name, AN, SEGS, exp_an, exp_segs);
      end
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic wr);
      IOBUS_ADDR = addr;
      IOBUS_OUT  = data;
      IOBUS_WR   = wr;
      tick();
      IOBUS_WR   = 1'b0;
      IOBUS_ADDR = '0;
      IOBUS_OUT  = '0;
   endtask

   task automatic align();
      while (ecount % 32 != 0) tick();
   endtask

   // One full refresh: first two cycles of each slot dark, then six lit cycles.
   task automatic check_frame(input string tag, input vec_t v);
      align();
      for (int j = 0; j < 32; j++) begin
         tick();
         if (j % 8 < 2)
            check($sformatf("%s_p%0d", tag, j), 4'hF, 8'hFF);
         else
            check($sformatf("%s_p%0d", tag, j), v.an[j/8], v.segs[j/8]);
      end
   endtask

   task automatic apply_vec(input vec_t v);
      if (!v.skip_wr) begin
         bus_write(CTRL_ADDR, {22'h0, v.ctrl}, 1'b1);
         bus_write(VALUE_ADDR, {16'h0, v.value}, 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 10'h20F, 16'h0000, {4'h7,4'hB,4'hD,4'hE}, {8'hC0,8'hC0,8'hC0,8'hC0}};
      vecs[1] = '{1'b0, 10'h20F, 16'h1234, {4'h7,4'hB,4'hD,4'hE}, {8'hF9,8'hA4,8'hB0,8'h99}};
      vecs[2] = '{1'b0, 10'h20F, 16'hABCD, {4'h7,4'hB,4'hD,4'hE}, {8'h88,8'h83,8'hC6,8'hA1}};
      vecs[3] = '{1'b0, 10'h20F, 16'h5F60, {4'h7,4'hB,4'hD,4'hE}, {8'h92,8'h8E,8'h82,8'hC0}};
      vecs[4] = '{1'b0, 10'h30F, 16'h0007, {4'hF,4'hF,4'hF,4'hE}, {8'hFF,8'hFF,8'hFF,8'hF8}};
      vecs[5] = '{1'b0, 10'h30F, 16'h0000, {4'hF,4'hF,4'hF,4'hE}, {8'hFF,8'hFF,8'hFF,8'hC0}};
      vecs[6] = '{1'b0, 10'h30F, 16'h0100, {4'hF,4'hB,4'hD,4'hE}, {8'hFF,8'hF9,8'hC0,8'hC0}};
      vecs[7] = '{1'b0, 10'h215, 16'h8888, {4'hF,4'hB,4'hF,4'hE}, {8'hFF,8'h80,8'hFF,8'h00}};
      vecs[8] = '{1'b0, 10'h3FF, 16'h00A5, {4'hF,4'hF,4'hD,4'hE}, {8'hFF,8'hFF,8'h08,8'h12}};
      vecs[9] = '{1'b0, 10'h00F, 16'h1234, {4'hF,4'hF,4'hF,4'hF}, {8'hFF,8'hFF,8'hFF,8'hFF}};

      // Reset: asserted between edges, outputs dark with and without clocks.
      #1 RST = 1'b1;
      #1 check("rst_async", 4'hF, 8'hFF);
      tick();
      tick();
      check("rst_held", 4'hF, 8'hFF);
      RST = 1'b0;
      ecount = 0;

      check_frame("v0", vecs[0]);
      apply_vec(vecs[1]);
      check_frame("v1", vecs[1]);

      // Foreign address and unstrobed write leave the display alone.
      bus_write(32'h1100C000, 32'h0000FFFF, 1'b1);
      bus_write(VALUE_ADDR, 32'h0000FFFF, 1'b0);
      check_frame("ign", vecs[1]);

      // Mid-slot write shows up one edge later in the same slot.
      align();
      repeat (4) tick();
      IOBUS_ADDR = VALUE_ADDR;
      IOBUS_OUT  = 32'h0000_0009;
      IOBUS_WR   = 1'b1;
      tick();
      IOBUS_WR   = 1'b0;
      check("wr_edge_k", 4'hE, 8'h99);
      tick();
      check("wr_edge_k1", 4'hE, 8'h90);

      // Write on the terminal-count edge; the next digit picks it up.
      while (ecount % 32 != 7) tick();
      IOBUS_ADDR = VALUE_ADDR;
      IOBUS_OUT  = 32'h0000_00C0;
      IOBUS_WR   = 1'b1;
      tick();
      IOBUS_WR   = 1'b0;
      check("tc_last", 4'hE, 8'h90);
      tick();
      check("tc_ghost0", 4'hF, 8'hFF);
      tick();
      check("tc_ghost1", 4'hF, 8'hFF);
      tick();
      check("tc_newdig", 4'hD, 8'hC6);

      for (int i = 2; i < 10; i++) begin
         apply_vec(vecs[i]);
         check_frame($sformatf("v%0d", i), vecs[i]);
      end

      // Async reset in the middle of slot 2 restores defaults.
      bus_write(CTRL_ADDR, 32'h0000_03FF, 1'b1);
      bus_write(VALUE_ADDR, 32'h0000_1234, 1'b1);
      align();
      repeat (20) tick();
      check("pre_rst", 4'hB, 8'h24);
      #2 RST = 1'b1;
      #1 check("mid_rst", 4'hF, 8'hFF);
      tick();
      check("mid_rst_clk", 4'hF, 8'hFF);
      RST = 1'b0;
      ecount = 0;
      check_frame("post_rst", vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
